// File: rtl/mips_mc_core_if.sv
// rtl/mips_mc_core_if.sv - unified instruction/data memory port of mips_mc_core
interface mips_mc_core_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS core, optional perf counters under MIPS_MC_PERF_CNT_EN
module mips_mc_core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mips_mc_core_if.master mem_if,
  output logic           trap_o,
  output logic [2:0]     state_dbg_o
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]    cycle_cnt_o,
  output logic [31:0]    instret_cnt_o
`endif
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("mips_mc_core: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 26 || ADDR_WIDTH > 32) begin : g_bad_addr_width
    $error("mips_mc_core: ADDR_WIDTH must be 26..32");
  end

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]           rf_q [32];
  logic                  rst_hold_q;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;
  logic                  retire;
  logic                  rtype_ok;
  logic                  legal;
  logic [31:0]           r_result;
  logic [31:0]           jmp_tmp;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, ea_sum;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ea_sum   = a_q + imm_sext;

  assign trap_o      = (state_q == S_TRAP);
  assign state_dbg_o = state_q;

  // R-type ALU result and funct legality
  always_comb begin
    rtype_ok = 1'b1;
    r_result = '0;
    case (funct)
      FN_ADD:  r_result = a_q + b_q;
      FN_SUB:  r_result = a_q - b_q;
      FN_AND:  r_result = a_q & b_q;
      FN_OR:   r_result = a_q | b_q;
      FN_SLT:  r_result = {31'b0, $signed(a_q) < $signed(b_q)};
      FN_SLL:  r_result = b_q << shamt;
      FN_SRL:  r_result = b_q >> shamt;
      default: rtype_ok = 1'b0;
    endcase
    legal = (op == OP_RTYPE) ? rtype_ok :
            (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
  end

  // next-state, datapath updates and memory port drive
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    a_d              = a_q;
    b_d              = b_q;
    alu_d            = alu_q;
    mdr_d            = mdr_q;
    rf_we            = 1'b0;
    rf_waddr         = '0;
    rf_wdata         = '0;
    retire           = 1'b0;
    jmp_tmp          = 32'(pc_q);
    mem_if.mem_req   = 1'b0;
    mem_if.mem_we    = 1'b0;
    mem_if.mem_addr  = pc_q;
    mem_if.mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        // one idle cycle after reset so a pending access is dropped cleanly
        mem_if.mem_req = !rst_hold_q;
        if (!rst_hold_q && mem_if.mem_ready) begin
          ir_d    = mem_if.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin alu_d = r_result;       state_d = S_WB; end
          OP_ADDI:  begin alu_d = ea_sum;         state_d = S_WB; end
          OP_LW, OP_SW: begin
            alu_d   = 32'(ADDR_WIDTH'(ea_sum));
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + ADDR_WIDTH'(imm_sext);
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            jmp_tmp[25:0] = ir_q[25:0];
            pc_d          = ADDR_WIDTH'(jmp_tmp);
            retire        = 1'b1;
            state_d       = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_if.mem_req   = 1'b1;
        mem_if.mem_we    = (op == OP_SW);
        mem_if.mem_addr  = ADDR_WIDTH'(alu_q);
        mem_if.mem_wdata = b_q;
        if (mem_if.mem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_if.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (op == OP_RTYPE) begin
          rf_waddr = rd;
          rf_wdata = alu_q;
        end else begin
          rf_waddr = rt;
          rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        end
      end
      default: state_d = S_TRAP;
    endcase
  end

  // architectural and pipeline-register state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      rst_hold_q <= 1'b1;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      rst_hold_q <= 1'b0;
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MIPS_MC_PERF_CNT_EN
  // free-running cycle and retired-instruction counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (retire) instret_cnt_o <= instret_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - self-checking bench for mips_mc_core against an instruction-level model
module tb_mips_mc_core;
  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trap;
  logic [2:0] state_dbg;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mips_mc_core_if #(.ADDR_WIDTH(AW)) mif ();

  mips_mc_core #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .mem_if(mif), .trap_o(trap), .state_dbg_o(state_dbg)
`ifdef MIPS_MC_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          base;
  } xact_t;

  xact_t       exp_q[$];
  logic [31:0] mem_tb  [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rf  [32];
  logic [31:0] ref_pc;

  // Instruction-level model: executes one instruction, queues the bus accesses it implies
  task automatic iss_step();
    logic [31:0] ins, a, b, sx, res, ea;
    int          op, fn, rs, rt, rd, sh;
    xact_t       x;
    ins = ref_mem[ref_pc[7:0]];
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rd = int'(ins[15:11]); sh = int'(ins[10:6]);  fn = int'(ins[5:0]);
    sx = {{16{ins[15]}}, ins[15:0]};
    a = ref_rf[rs]; b = ref_rf[rt];
    x.fetch = 1; x.we = 0; x.addr = ref_pc; x.wdata = '0;
    x.base = (op == 4 || op == 2) ? 3 : (op == 'h23) ? 5 : 4;
    exp_q.push_back(x);
    ref_pc = ref_pc + 1;
    res = '0;
    case (op)
      0: begin
        case (fn)
          'h20: res = a + b;
          'h22: res = a - b;
          'h24: res = a & b;
          'h25: res = a | b;
          'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          'h00: res = b << sh;
          'h02: res = b >> sh;
          default: res = '0;
        endcase
        if (rd != 0) ref_rf[rd] = res;
      end
      'h08: if (rt != 0) ref_rf[rt] = a + sx;
      'h23: begin
        ea = a + sx;
        x.fetch = 0; x.we = 0; x.addr = ea; x.base = 0;
        exp_q.push_back(x);
        if (rt != 0) ref_rf[rt] = ref_mem[ea[7:0]];
      end
      'h2b: begin
        ea = a + sx;
        x.fetch = 0; x.we = 1; x.addr = ea; x.wdata = b; x.base = 0;
        exp_q.push_back(x);
        ref_mem[ea[7:0]] = b;
      end
      'h04: if (a == b) ref_pc = ref_pc + sx;
      'h02: ref_pc = {ref_pc[31:26], ins[25:0]};
      default: ;
    endcase
  endtask

  bit          pend, have_prev, directed;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  int          wait_left, cyc, prev_start, prev_base, waits_acc;

  // One clock of the memory responder: samples at negedge, answers for the next posedge
  task automatic bus_cycle();
    xact_t e;
    @(negedge clk);
    cyc++;
    if (mif.mem_req === 1'b1) begin
      if (!pend) begin
        pend = 1; p_we = mif.mem_we; p_addr = mif.mem_addr; p_wdata = mif.mem_wdata;
        wait_left = directed ? (p_we ? 3 : 0) : (($urandom % 2) != 0 ? 0 : int'($urandom_range(1, 3)));
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          check("kind_is_fetch", 64'(state_dbg == 3'd0), 64'(e.fetch));
          if (e.fetch) begin
            if (have_prev) check("latency", 64'(cyc - prev_start), 64'(prev_base + waits_acc));
            have_prev = 1; prev_start = cyc; prev_base = e.base; waits_acc = 0;
          end
        end
      end else begin
        check("hold_addr", 64'(mif.mem_addr), 64'(p_addr));
        check("hold_we", 64'(mif.mem_we), 64'(p_we));
        if (p_we) check("hold_wdata", 64'(mif.mem_wdata), 64'(p_wdata));
      end
      if (wait_left == 0) begin
        mif.mem_ready = 1'b1;
        mif.mem_rdata = mem_tb[p_addr[7:0]];
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("xfer_we", 64'(p_we), 64'(e.we));
          check("xfer_addr", 64'(p_addr), 64'(e.addr));
          if (e.we) check("xfer_wdata", 64'(p_wdata), 64'(e.wdata));
        end
        if (p_we) mem_tb[p_addr[7:0]] = p_wdata;
        pend = 0;
      end else begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = $urandom;
        wait_left--;
        waits_acc++;
      end
    end else begin
      pend = 0;
      mif.mem_ready = 1'($urandom % 2);
      mif.mem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mif.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; pend = 0; have_prev = 0; waits_acc = 0;
    check("rst_req", 64'(mif.mem_req), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
`ifdef MIPS_MC_PERF_CNT_EN
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("rst_instret_cnt", 64'(instret_cnt), 64'd0);
`endif
  endtask

  task automatic run_prog(input int n_instr, input int budget);
    int c = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_tb[i];
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    ref_pc = RPC;
    exp_q.delete();
    for (int i = 0; i < n_instr; i++) iss_step();
    do_reset();
    while (exp_q.size() > 0 && c < budget) begin
      bus_cycle();
      c++;
    end
    check("prog_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic gen_prog();
    int k, rs, rt, rd, mx;
    int fns[5] = '{'h20, 'h22, 'h24, 'h25, 'h2a};
    for (int i = 0; i < 256; i++) mem_tb[i] = $urandom;
    for (int i = 0; i < 47; i++) begin
      k = int'($urandom % 10);
      rs = int'($urandom % 8); rt = int'($urandom % 8); rd = int'($urandom % 8);
      case (k)
        0, 1, 2: mem_tb[16+i] = enc_i('h08, rs, rt, int'($urandom % 65536));
        3, 4:    mem_tb[16+i] = enc_r(rs, rt, rd, 0, fns[$urandom % 5]);
        5:       mem_tb[16+i] = enc_r(rs, rt, rd, int'($urandom % 32), ($urandom % 2) != 0 ? 'h02 : 'h00);
        6:       mem_tb[16+i] = enc_i('h23, 0, rt, 64 + int'($urandom % 64));
        7:       mem_tb[16+i] = enc_i('h2b, 0, rt, 64 + int'($urandom % 64));
        8: begin
          mx = (46 - i < 3) ? 46 - i : 3;
          mem_tb[16+i] = enc_i('h04, rs, rt, int'($urandom_range(0, mx)));
        end
        default: mem_tb[16+i] = enc_j(16 + int'($urandom_range(i + 1, 47)));
      endcase
    end
    mem_tb[16+47] = enc_j(16);
  endtask

  task automatic trap_test(input logic [31:0] word);
    int req_cnt = 0;
`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] cc0;
`endif
    mem_tb[16] = word;
    do_reset();
    @(negedge clk);
    check("first_fetch_req", 64'(mif.mem_req), 64'd1);
    check("first_fetch_addr", 64'(mif.mem_addr), 64'(RPC));
    check("first_fetch_we", 64'(mif.mem_we), 64'd0);
    check("first_fetch_trap", 64'(trap), 64'd0);
    mif.mem_ready = 1'b1; mif.mem_rdata = word;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    check("decode_state", 64'(state_dbg), 64'd1);
    check("decode_trap", 64'(trap), 64'd0);
    @(negedge clk);
    check("trap_set", 64'(trap), 64'd1);
    check("trap_state", 64'(state_dbg), 64'd5);
`ifdef MIPS_MC_PERF_CNT_EN
    cc0 = cycle_cnt;
`endif
    for (int i = 0; i < 20; i++) begin
      if (mif.mem_req !== 1'b0) req_cnt++;
      mif.mem_ready = 1'($urandom % 2);
      @(negedge clk);
    end
    check("trap_req_cycles", 64'(req_cnt), 64'd0);
    check("trap_held", 64'(trap), 64'd1);
`ifdef MIPS_MC_PERF_CNT_EN
    check("trap_cycle_cnt_frozen", 64'(cycle_cnt), 64'(cc0));
`endif
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    cyc = 0; directed = 0;

    trap_test(32'hFC00_0000);
    trap_test(enc_r(1, 2, 3, 0, 'h21));

    do_reset();
    @(negedge clk);
    check("midfetch_req", 64'(mif.mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midfetch_rst_req", 64'(mif.mem_req), 64'd0);
    check("midfetch_rst_state", 64'(state_dbg), 64'd0);
`ifdef MIPS_MC_PERF_CNT_EN
    check("midfetch_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("midfetch_instret_cnt", 64'(instret_cnt), 64'd0);
`endif
    @(negedge clk);
    check("midfetch_refetch_req", 64'(mif.mem_req), 64'd1);
    check("midfetch_refetch_addr", 64'(mif.mem_addr), 64'(RPC));

    for (int i = 0; i < 256; i++) mem_tb[i] = $urandom;
    mem_tb[16] = enc_i('h08, 0, 1, 5);
    mem_tb[17] = enc_r(1, 1, 2, 0, 'h20);
    mem_tb[18] = enc_i('h2b, 0, 2, 3);
    mem_tb[19] = enc_i('h23, 0, 3, 3);
    mem_tb[20] = enc_i('h04, 3, 2, 1);
    mem_tb[21] = enc_i('h08, 0, 4, 99);
    mem_tb[22] = enc_i('h04, 1, 0, 2);
    mem_tb[23] = enc_r(0, 1, 5, 0, 'h22);
    mem_tb[24] = enc_r(5, 0, 6, 0, 'h2a);
    mem_tb[25] = enc_r(0, 5, 7, 28, 'h02);
    mem_tb[26] = enc_r(0, 1, 8, 4, 'h00);
    mem_tb[27] = enc_r(5, 2, 9, 0, 'h24);
    mem_tb[28] = enc_r(5, 2, 10, 0, 'h25);
    mem_tb[29] = enc_i('h08, 0, 11, 'hFFFF);
    mem_tb[30] = enc_r(1, 5, 12, 0, 'h2a);
    for (int r = 5; r <= 12; r++) mem_tb[26 + r] = enc_i('h2b, 0, r, r - 1);
    mem_tb[39] = enc_j(41);
    mem_tb[40] = enc_i('h08, 0, 4, 1);
    mem_tb[41] = enc_i('h04, 1, 1, 'hFFFF);
    directed = 1;
    run_prog(26, 2000);
    check("directed_sw_value", 64'(mem_tb[3]), 64'd10);
    directed = 0;

    for (int p = 0; p < 3; p++) begin
      gen_prog();
      run_prog(150, 6000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
Multi-cycle MIPS core that succeeds the single-cycle top. It executes the same ISA subset but walks each instruction through a fetch/decode/execute/memory/writeback state machine. Instruction and data accesses share one unified memory port with a req/ready handshake, so the core stalls on slow memory. It contains its own 32-entry register file and ALU, and sits as the CPU tile in front of a shared memory or bus bridge.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and PC (word address, 26..32)
RESET_PC, 0, PC value loaded on reset
DATA_WIDTH, 32, fixed at 32 (instruction width); any other value is an elaboration error

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  output  ADDR_WIDTH  word address
mem_wdata  output  32  store data
mem_ready  input  1  access complete this cycle
mem_rdata  input  32  read data, valid when mem_ready is high
trap  output  1  illegal opcode or funct seen; core stopped
state_dbg  output  3  current FSM state encoding

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-handshake):
  - state = FETCH, PC = RESET_PC.
  - IR, A, B, ALUOut and MDR = 0; all registers = 0; trap = 0.
  - mem_req drops in the cycle after the reset edge. The memory must discard any pending access.
- Registers: r0 reads 0 and writes to it are ignored.
- Supported ISA: R-type add, sub, and, or, slt, sll, srl; I-type addi, lw, sw, beq; J-type j. Anything else goes to TRAP.
- PC is word-addressed and increments by 1.
- States and transitions:
  - FETCH:
    - mem_req = 1, mem_we = 0, mem_addr = PC.
    - While mem_ready = 0, hold; addr and we stay stable.
    - On mem_ready = 1: IR <= mem_rdata, PC <= PC + 1, go to DECODE.
  - DECODE:
    - A <= reg[rs], B <= reg[rt]; opcode and funct are checked.
    - Illegal: go to TRAP. Otherwise go to EXECUTE.
  - EXECUTE:
    - R-type: ALUOut <= A op B (shifts use shamt on B), go to WB.
    - addi: ALUOut <= A + sext(imm), go to WB.
    - lw/sw: ALUOut <= A + sext(imm), truncated to ADDR_WIDTH; go to MEM.
    - beq: if A == B, PC <= PC + sext(imm) (PC is already incremented); go to FETCH.
    - j: PC <= {PC[ADDR_WIDTH-1:26], target}; go to FETCH.
  - MEM:
    - mem_req = 1, mem_addr = ALUOut, mem_we = (sw), mem_wdata = B.
    - Hold until mem_ready. Then sw goes to FETCH; lw does MDR <= mem_rdata and goes to WB.
  - WB:
    - R-type writes reg[rd] <= ALUOut.
    - addi writes reg[rt] <= ALUOut.
    - lw writes reg[rt] <= MDR.
    - Then go to FETCH.
  - TRAP: trap = 1, mem_req = 0; stay until reset.
- Handshake:
  - A transfer completes on a clk edge where mem_req and mem_ready are both high.
  - mem_ready may be high in the first req cycle (zero wait states).
  - mem_ready is ignored while mem_req = 0.
  - mem_req is never deasserted before completion except by reset.
- Latency with zero-wait memory, in clocks: beq/j 3, sw 4, R-type/addi 4, lw 5. Each wait cycle adds 1.
- Arithmetic: 32-bit wrap-around with no overflow exception. slt is signed. sll/srl are logical.
- PC wraps modulo 2^ADDR_WIDTH.
- state_dbg encoding: FETCH 0, DECODE 1, EXECUTE 2, MEM 3, WB 4, TRAP 5.

Optional Feature:
MIPS_MC_PERF_CNT_EN:
- When defined, two extra output ports are added:
  - cycle_cnt (32): increments every clock when not in reset and not in TRAP.
  - instret_cnt (32): increments on every FETCH-bound transition out of EXECUTE, MEM or WB.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 0x10 and zero-wait memory -> first mem_req cycle has mem_addr = 0x10, mem_we = 0, trap = 0.
- addi r1,r0,5 then add r2,r1,r1, zero-wait -> at 8 clocks, reg[2] = 10 and PC = 2; no third instruction has retired.
- sw r2,3(r0) with mem_ready held low 3 cycles in MEM -> mem_addr = 3, mem_we = 1, mem_wdata = 10 stable all 4 cycles. Next fetch addr = 3 (PC after 2 prior instructions + 1).
- beq r1,r1,-1 at PC 4 -> next fetch addr = 4 (loops). beq r1,r0,+2 at PC 4 -> next fetch addr = 5.
- Opcode 0x3F at PC 0 -> trap = 1 at end of DECODE, mem_req stays 0 for 20 cycles. A rst pulse then refetches at RESET_PC.
- rst asserted during a FETCH wait (mem_ready = 0) -> next cycle mem_req = 0, state_dbg = 0; the following cycle fetches at RESET_PC. With MIPS_MC_PERF_CNT_EN, both counters read 0.
